// File: rtl/channel_reset_sequencer_if.sv
// Request/enable inputs and reset/status outputs of the per-channel reset sequencer.
interface channel_reset_sequencer_if #(
    parameter int NUM_PORTS = 8
);
    logic [NUM_PORTS-1:0] i_rst_req;
    logic [NUM_PORTS-1:0] i_ch_en;
    logic [NUM_PORTS-1:0] o_rst;
    logic [NUM_PORTS-1:0] o_rst_n;
    logic                 o_all_ready;
    logic                 o_busy;

    // System reset controller side: drives requests and enables.
    modport master (
        output i_rst_req, i_ch_en,
        input  o_rst, o_rst_n, o_all_ready, o_busy
    );

    // Sequencer side.
    modport slave (
        input  i_rst_req, i_ch_en,
        output o_rst, o_rst_n, o_all_ready, o_busy
    );
endinterface

// File: rtl/channel_reset_sequencer.sv
// Per-channel reset generator: synchronises async reset requests, holds each
// channel in reset for a minimum quiet time, releases channels one by one in
// ascending order after power-up, then re-resets single channels on demand.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_INIT    | all channels in reset, waiting for HOLD_CYCLES of no request
// ST_STAGGER | releasing channel idx at the start of each stagger slot
// ST_RUN     | channels independent, each with its own hold timer
module channel_reset_sequencer #(
    parameter int NUM_PORTS      = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    channel_reset_sequencer_if.slave bus
);
    localparam int CNT_MAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STG_LAST  = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_PORTS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_STAGGER = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0][NUM_PORTS-1:0] sync_q;
    logic [NUM_PORTS-1:0]                  act;

    state_t                           state_q, state_d;
    logic [CNT_W-1:0]                 hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]                 stg_cnt_q, stg_cnt_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [NUM_PORTS-1:0][CNT_W-1:0]  pc_q, pc_d;
    logic [NUM_PORTS-1:0]             rst_q, rst_d;
    logic [NUM_PORTS-1:0]             rst_n_q;
    logic                             rdy_q, rdy_d;
    logic                             busy_q, busy_d;

    // Request synchronisers; preset to 1 so every channel looks requested out of reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q[0] <= bus.i_rst_req;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // A disabled channel's request is ignored; disabling is handled separately.
    assign act = sync_q[SYNC_STAGES-1] & bus.i_ch_en;

    // Next-state and next-output decode for the sequencer FSM.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        stg_cnt_d  = stg_cnt_q;
        idx_d      = idx_q;
        pc_d       = pc_q;
        rst_d      = rst_q;

        case (state_q)
            ST_INIT: begin
                rst_d = '1;
                pc_d  = '0;
                if (|act) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = ST_STAGGER;
                    hold_cnt_d = '0;
                    stg_cnt_d  = '0;
                    idx_d      = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_ONE;
                end
            end

            ST_STAGGER: begin
                pc_d = '0;
                if (|act) begin
                    rst_d      = '1;
                    hold_cnt_d = '0;
                    state_d    = ST_INIT;
                end else begin
                    // Disabled channels still use their slot, they just stay in reset.
                    if (stg_cnt_q == '0) begin
                        for (int k = 0; k < NUM_PORTS; k++) begin
                            if (IDX_W'(k) == idx_q) begin
                                rst_d[k] = ~bus.i_ch_en[k];
                            end
                        end
                    end
                    if (stg_cnt_q == STG_LAST) begin
                        stg_cnt_d = '0;
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_RUN;
                        end else begin
                            idx_d = idx_q + IDX_ONE;
                        end
                    end else begin
                        stg_cnt_d = stg_cnt_q + CNT_ONE;
                    end
                end
            end

            ST_RUN: begin
                // A disabled channel is held like a requested one, so re-enabling
                // starts the hold timer exactly as a request drop would.
                for (int k = 0; k < NUM_PORTS; k++) begin
                    if (act[k] || !bus.i_ch_en[k]) begin
                        rst_d[k] = 1'b1;
                        pc_d[k]  = '0;
                    end else if (rst_q[k]) begin
                        if (pc_q[k] == HOLD_LAST) begin
                            rst_d[k] = 1'b0;
                            pc_d[k]  = '0;
                        end else begin
                            pc_d[k] = pc_q[k] + CNT_ONE;
                        end
                    end else begin
                        pc_d[k] = '0;
                    end
                end
            end

            default: begin
                state_d    = ST_INIT;
                rst_d      = '1;
                hold_cnt_d = '0;
            end
        endcase

        // Readiness tracks the reset outputs being registered this edge so it
        // never overlaps a channel in reset; RUN gating lags the state by one edge.
        rdy_d  = (state_q == ST_RUN) & ~|(rst_d & bus.i_ch_en);
        busy_d = (state_q != ST_RUN);
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_INIT;
            hold_cnt_q <= '0;
            stg_cnt_q  <= '0;
            idx_q      <= '0;
            pc_q       <= '0;
            rst_q      <= '1;
            rst_n_q    <= '0;
            rdy_q      <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            stg_cnt_q  <= stg_cnt_d;
            idx_q      <= idx_d;
            pc_q       <= pc_d;
            rst_q      <= rst_d;
            rst_n_q    <= ~rst_d;
            rdy_q      <= rdy_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.o_rst       = rst_q;
    assign bus.o_rst_n     = rst_n_q;
    assign bus.o_all_ready = rdy_q;
    assign bus.o_busy      = busy_q;

endmodule
